// File: rtl/feed_msg_decoder.sv
// feed_msg_decoder: turns a byte-serial market feed (add / cancel / trade)
// into one command strobe per message for the downstream book builder.
`timescale 1ns/1ps
module feed_msg_decoder #(
    parameter int NUM_STOCK = 2
) (
    input  logic        clk_100mhz,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        builder_done,
    output logic        start,
    output logic [2:0]  request,
    output logic [1:0]  stock_to_add,
    output logic        order_side,
    output logic [15:0] order_price,
    output logic [15:0] order_qty,
    output logic [15:0] order_id,
    output logic        delete,
    output logic [15:0] quantity,
    output logic        msg_err,
    output logic [15:0] msg_count,
    output logic [7:0]  err_count
);

    localparam logic [1:0] S_TYPE  = 2'd0;
    localparam logic [1:0] S_BODY  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;
    localparam logic [1:0] S_WAIT  = 2'd3;

    // Message kind doubles as the request code driven to the builder.
    localparam logic [1:0] K_ADD    = 2'd0;
    localparam logic [1:0] K_CANCEL = 2'd1;
    localparam logic [1:0] K_TRADE  = 2'd2;

    localparam logic [7:0] TYPE_ADD    = 8'h41;
    localparam logic [7:0] TYPE_CANCEL = 8'h58;
    localparam logic [7:0] TYPE_TRADE  = 8'h45;

    // Body lengths (bytes after the type byte).
    localparam logic [3:0] LEN_ADD    = 4'd8;
    localparam logic [3:0] LEN_CANCEL = 4'd3;
    localparam logic [3:0] LEN_TRADE  = 4'd5;

    // A stock byte can never reach 256, so a larger NUM_STOCK accepts everything.
    localparam bit         ALL_STOCK_VALID = (NUM_STOCK > 255);
    localparam logic [7:0] STOCK_LIMIT     = 8'(NUM_STOCK);

    logic [1:0]  state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  stock_q, stock_d;
    logic        side_q, side_d;
    logic [15:0] price_q, price_d;
    logic [15:0] qty_q, qty_d;
    logic [15:0] id_q, id_d;

    logic [2:0]  request_q;
    logic [1:0]  stock_out_q;
    logic        side_out_q;
    logic [15:0] price_out_q;
    logic [15:0] order_qty_q;
    logic [15:0] id_out_q;
    logic        delete_q;
    logic [15:0] quantity_q;
    logic        msg_err_q;
    logic [15:0] msg_count_q;
    logic [7:0]  err_count_q;

    logic        ready_int;
    logic        accept;
    logic        stock_ok;
    logic        issue_cmd;
    logic        bad_msg;

    assign ready_int = (state_q == S_TYPE) || (state_q == S_BODY);
    assign accept    = in_valid && ready_int;
    // The stock byte is always the first body byte, so it is settled in
    // stock_q well before the last body byte arrives.
    assign stock_ok  = ALL_STOCK_VALID || (stock_q < STOCK_LIMIT);

    // Next-state logic: type decode, field shifting and message completion.
    always_comb begin
        state_d   = state_q;
        kind_d    = kind_q;
        cnt_d     = cnt_q;
        stock_d   = stock_q;
        side_d    = side_q;
        price_d   = price_q;
        qty_d     = qty_q;
        id_d      = id_q;
        issue_cmd = 1'b0;
        bad_msg   = 1'b0;
        case (state_q)
            S_TYPE: begin
                if (accept) begin
                    stock_d = '0;
                    side_d  = 1'b0;
                    price_d = '0;
                    qty_d   = '0;
                    id_d    = '0;
                    case (in_byte)
                        TYPE_ADD: begin
                            kind_d  = K_ADD;
                            cnt_d   = LEN_ADD;
                            state_d = S_BODY;
                        end
                        TYPE_CANCEL: begin
                            kind_d  = K_CANCEL;
                            cnt_d   = LEN_CANCEL;
                            state_d = S_BODY;
                        end
                        TYPE_TRADE: begin
                            kind_d  = K_TRADE;
                            cnt_d   = LEN_TRADE;
                            state_d = S_BODY;
                        end
                        default: bad_msg = 1'b1;
                    endcase
                end
            end
            S_BODY: begin
                if (accept) begin
                    cnt_d = cnt_q - 4'd1;
                    case (kind_q)
                        K_ADD: begin
                            case (cnt_q)
                                4'd8:       stock_d = in_byte;
                                4'd7:       side_d  = in_byte[0];
                                4'd6, 4'd5: price_d = {price_q[7:0], in_byte};
                                4'd4, 4'd3: qty_d   = {qty_q[7:0], in_byte};
                                default:    id_d    = {id_q[7:0], in_byte};
                            endcase
                        end
                        K_CANCEL: begin
                            case (cnt_q)
                                4'd3:    stock_d = in_byte;
                                default: id_d    = {id_q[7:0], in_byte};
                            endcase
                        end
                        default: begin
                            case (cnt_q)
                                4'd5:       stock_d = in_byte;
                                4'd4, 4'd3: id_d    = {id_q[7:0], in_byte};
                                default:    qty_d   = {qty_q[7:0], in_byte};
                            endcase
                        end
                    endcase
                    if (cnt_q == 4'd1) begin
                        if (stock_ok) begin
                            state_d   = S_ISSUE;
                            issue_cmd = 1'b1;
                        end else begin
                            state_d = S_TYPE;
                            bad_msg = 1'b1;
                        end
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (builder_done) state_d = S_TYPE;
            end
            default: state_d = S_TYPE;
        endcase
    end

    // Parser registers: FSM state, message kind, byte counter and raw fields.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state_q <= S_TYPE;
            kind_q  <= K_ADD;
            cnt_q   <= '0;
            stock_q <= '0;
            side_q  <= 1'b0;
            price_q <= '0;
            qty_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            cnt_q   <= cnt_d;
            stock_q <= stock_d;
            side_q  <= side_d;
            price_q <= price_d;
            qty_q   <= qty_d;
            id_q    <= id_d;
        end
    end

    // Command and status registers: loaded as the message completes so they
    // are valid in the start cycle and held until the next command.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            request_q   <= '0;
            stock_out_q <= '0;
            side_out_q  <= 1'b0;
            price_out_q <= '0;
            order_qty_q <= '0;
            id_out_q    <= '0;
            delete_q    <= 1'b0;
            quantity_q  <= '0;
            msg_err_q   <= 1'b0;
            msg_count_q <= '0;
            err_count_q <= '0;
        end else begin
            msg_err_q <= bad_msg;
            if (issue_cmd) begin
                request_q   <= {1'b0, kind_q};
                stock_out_q <= stock_q[1:0];
                side_out_q  <= (kind_q == K_ADD) ? side_d : 1'b0;
                price_out_q <= (kind_q == K_ADD) ? price_d : 16'd0;
                order_qty_q <= (kind_q == K_ADD) ? qty_d : 16'd0;
                id_out_q    <= id_d;
                delete_q    <= (kind_q == K_CANCEL);
                quantity_q  <= (kind_q == K_TRADE) ? qty_d : 16'd0;
                msg_count_q <= msg_count_q + 16'd1;
            end
            if (bad_msg && (err_count_q != 8'hFF)) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    assign in_ready     = ready_int && !reset;
    assign start        = (state_q == S_ISSUE);
    assign request      = request_q;
    assign stock_to_add = stock_out_q;
    assign order_side   = side_out_q;
    assign order_price  = price_out_q;
    assign order_qty    = order_qty_q;
    assign order_id     = id_out_q;
    assign delete       = delete_q;
    assign quantity     = quantity_q;
    assign msg_err      = msg_err_q;
    assign msg_count    = msg_count_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_feed_msg_decoder.sv
// tb_feed_msg_decoder: directed and randomized feed messages checked against
// a message-level reference model of the decoder.
`timescale 1ns/1ps
module tb_feed_msg_decoder;

    localparam int NS = 2;

    typedef logic [7:0] byteQ_t [$];

    typedef struct packed {
        logic        err;
        logic [2:0]  req;
        logic [1:0]  stock;
        logic        side;
        logic [15:0] price;
        logic [15:0] oqty;
        logic [15:0] id;
        logic        del;
        logic [15:0] qty;
    } expT;

    logic        clk_100mhz = 1'b0;
    logic        reset;
    logic [7:0]  inByte;
    logic        inValid;
    logic        inReady;
    logic        builderDone;
    logic        start;
    logic [2:0]  request;
    logic [1:0]  stockToAdd;
    logic        orderSide;
    logic [15:0] orderPrice;
    logic [15:0] orderQty;
    logic [15:0] orderId;
    logic        deleteOut;
    logic [15:0] quantity;
    logic        msgErr;
    logic [15:0] msgCount;
    logic [7:0]  errCount;

    int checkCount = 0;
    int passCount = 0;
    int failCount = 0;
    int countExp = 0;
    int errExp = 0;
    int startsExp = 0;
    int errPulsesExp = 0;
    int startSeen = 0;
    int errSeen = 0;
    expT lastExp = '0;

    feed_msg_decoder #(.NUM_STOCK(NS)) dut (
        .clk_100mhz   (clk_100mhz),
        .reset        (reset),
        .in_byte      (inByte),
        .in_valid     (inValid),
        .in_ready     (inReady),
        .builder_done (builderDone),
        .start        (start),
        .request      (request),
        .stock_to_add (stockToAdd),
        .order_side   (orderSide),
        .order_price  (orderPrice),
        .order_qty    (orderQty),
        .order_id     (orderId),
        .delete       (deleteOut),
        .quantity     (quantity),
        .msg_err      (msgErr),
        .msg_count    (msgCount),
        .err_count    (errCount)
    );

    // 100 MHz clock.
    always #5 clk_100mhz = ~clk_100mhz;

    // Count strobes away from the active edge so every pulse is seen once.
    always @(negedge clk_100mhz) begin
        if (start === 1'b1) startSeen++;
        if (msgErr === 1'b1) errSeen++;
    end

    // Hard stop in case a wait ever runs away.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge clk_100mhz);
        #1;
    endtask

    // Reference model: decode a whole message straight from its byte list.
    function automatic expT model(input byteQ_t m);
        expT e;
        logic [7:0] b1, b2, b3, b4, b5, b6, b7, b8;
        e = '0;
        b1 = (m.size() > 1) ? m[1] : 8'h00;
        b2 = (m.size() > 2) ? m[2] : 8'h00;
        b3 = (m.size() > 3) ? m[3] : 8'h00;
        b4 = (m.size() > 4) ? m[4] : 8'h00;
        b5 = (m.size() > 5) ? m[5] : 8'h00;
        b6 = (m.size() > 6) ? m[6] : 8'h00;
        b7 = (m.size() > 7) ? m[7] : 8'h00;
        b8 = (m.size() > 8) ? m[8] : 8'h00;
        e.stock = b1[1:0];
        case (m[0])
            8'h41: begin
                e.req   = 3'd0;
                e.side  = b2[0];
                e.price = {b3, b4};
                e.oqty  = {b5, b6};
                e.id    = {b7, b8};
                e.err   = (int'(b1) >= NS);
            end
            8'h58: begin
                e.req = 3'd1;
                e.del = 1'b1;
                e.id  = {b2, b3};
                e.err = (int'(b1) >= NS);
            end
            8'h45: begin
                e.req = 3'd2;
                e.id  = {b2, b3};
                e.qty = {b4, b5};
                e.err = (int'(b1) >= NS);
            end
            default: begin
                e     = '0;
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    task automatic sendByte(input logic [7:0] b, input int gap);
        int n;
        inValid = 1'b0;
        repeat (gap) stepCycle();
        inByte  = b;
        inValid = 1'b1;
        n = 0;
        while (inReady !== 1'b1 && n < 64) begin
            stepCycle();
            n++;
        end
        if (inReady !== 1'b1) checkOutput("ready_timeout", 32'(inReady), 32'd1);
        stepCycle();
        inValid = 1'b0;
        inByte  = 8'($urandom);
    endtask

    task automatic applyStimulus(input byteQ_t msg, input int maxGap);
        for (int i = 0; i < msg.size(); i++) begin
            sendByte(msg[i], (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0);
        end
    endtask

    task automatic checkAllZero(input string tag);
        $display("[TB] zero-state checks: %s", tag);
        checkOutput("zero_in_ready", 32'(inReady), 32'd0);
        checkOutput("zero_start", 32'(start), 32'd0);
        checkOutput("zero_msg_err", 32'(msgErr), 32'd0);
        checkOutput("zero_request", 32'(request), 32'd0);
        checkOutput("zero_stock", 32'(stockToAdd), 32'd0);
        checkOutput("zero_side", 32'(orderSide), 32'd0);
        checkOutput("zero_price", 32'(orderPrice), 32'd0);
        checkOutput("zero_order_qty", 32'(orderQty), 32'd0);
        checkOutput("zero_order_id", 32'(orderId), 32'd0);
        checkOutput("zero_delete", 32'(deleteOut), 32'd0);
        checkOutput("zero_quantity", 32'(quantity), 32'd0);
        checkOutput("zero_msg_count", 32'(msgCount), 32'd0);
        checkOutput("zero_err_count", 32'(errCount), 32'd0);
    endtask

    task automatic finishCommand(input int doneDelay, input bit overlap);
        if (overlap) begin
            builderDone = 1'b1;
            stepCycle();
            checkOutput("overlap_no_early_exit", 32'(inReady), 32'd0);
            checkOutput("start_one_cycle", 32'(start), 32'd0);
            stepCycle();
            builderDone = 1'b0;
            checkOutput("overlap_exit", 32'(inReady), 32'd1);
        end else begin
            stepCycle();
            checkOutput("start_one_cycle", 32'(start), 32'd0);
            checkOutput("wait_ready_low", 32'(inReady), 32'd0);
            repeat (doneDelay) stepCycle();
            checkOutput("wait_hold", 32'(inReady), 32'd0);
            builderDone = 1'b1;
            stepCycle();
            builderDone = 1'b0;
            checkOutput("done_ready", 32'(inReady), 32'd1);
        end
        checkOutput("hold_id_after_done", 32'(orderId), 32'(lastExp.id));
        checkOutput("hold_request_after_done", 32'(request), 32'(lastExp.req));
    endtask

    task automatic runMessage(input byteQ_t msg, input int maxGap, input int doneDelay, input bit overlap);
        expT e;
        e = model(msg);
        applyStimulus(msg, maxGap);
        if (e.err) begin
            errExp = (errExp >= 255) ? 255 : errExp + 1;
            errPulsesExp++;
            checkOutput("err_pulse", 32'(msgErr), 32'd1);
            checkOutput("err_no_start", 32'(start), 32'd0);
            checkOutput("err_back_in_type", 32'(inReady), 32'd1);
            stepCycle();
            checkOutput("err_one_cycle", 32'(msgErr), 32'd0);
            checkOutput("err_count", 32'(errCount), 32'(errExp));
            checkOutput("err_hold_request", 32'(request), 32'(lastExp.req));
            checkOutput("err_hold_id", 32'(orderId), 32'(lastExp.id));
            checkOutput("err_hold_msg_count", 32'(msgCount), 32'(countExp));
        end else begin
            countExp++;
            startsExp++;
            lastExp = e;
            checkOutput("start", 32'(start), 32'd1);
            checkOutput("issue_ready_low", 32'(inReady), 32'd0);
            checkOutput("request", 32'(request), 32'(e.req));
            checkOutput("stock_to_add", 32'(stockToAdd), 32'(e.stock));
            checkOutput("order_side", 32'(orderSide), 32'(e.side));
            checkOutput("order_price", 32'(orderPrice), 32'(e.price));
            checkOutput("order_qty", 32'(orderQty), 32'(e.oqty));
            checkOutput("order_id", 32'(orderId), 32'(e.id));
            checkOutput("delete", 32'(deleteOut), 32'(e.del));
            checkOutput("quantity", 32'(quantity), 32'(e.qty));
            checkOutput("msg_count", 32'(msgCount), 32'(countExp));
            finishCommand(doneDelay, overlap);
        end
    endtask

    task automatic buildRandom(output byteQ_t m);
        int kind;
        logic [7:0] stock;
        logic [7:0] b;
        m.delete();
        kind = int'($urandom_range(0, 9));
        if ($urandom_range(0, 6) == 0) stock = 8'($urandom_range(NS, 255));
        else stock = 8'($urandom_range(0, NS - 1));
        if (kind < 3) begin
            m.push_back(8'h41);
            m.push_back(stock);
            repeat (7) m.push_back(8'($urandom));
        end else if (kind < 6) begin
            m.push_back(8'h58);
            m.push_back(stock);
            repeat (2) m.push_back(8'($urandom));
        end else if (kind < 9) begin
            m.push_back(8'h45);
            m.push_back(stock);
            repeat (4) m.push_back(8'($urandom));
        end else begin
            b = 8'($urandom);
            while (b == 8'h41 || b == 8'h58 || b == 8'h45) b = 8'($urandom);
            m.push_back(b);
        end
    endtask

    initial begin
        byteQ_t msg;
        reset       = 1'b1;
        inByte      = 8'h00;
        inValid     = 1'b0;
        builderDone = 1'b0;

        repeat (3) stepCycle();
        checkAllZero("power-on reset");
        reset = 1'b0;
        stepCycle();
        checkOutput("ready_after_reset", 32'(inReady), 32'd1);

        $display("[TB] add message, continuous valid");
        msg = '{8'h41, 8'h01, 8'h01, 8'h12, 8'h34, 8'h00, 8'h64, 8'hAB, 8'hCD};
        runMessage(msg, 0, 1, 1'b0);

        $display("[TB] cancel message with valid gaps");
        msg = '{8'h58, 8'h00, 8'h00, 8'h07};
        runMessage(msg, 3, 2, 1'b0);

        $display("[TB] trade message");
        msg = '{8'h45, 8'h01, 8'h00, 8'h05, 8'h00, 8'h0A};
        runMessage(msg, 0, 0, 1'b0);

        $display("[TB] builder_done overlapping the issue cycle");
        msg = '{8'h41, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h20, 8'h00, 8'h30};
        runMessage(msg, 1, 0, 1'b1);

        $display("[TB] unknown type byte");
        msg = '{8'h7F};
        runMessage(msg, 0, 0, 1'b0);

        $display("[TB] add with out-of-range stock");
        msg = '{8'h41, 8'h02, 8'h01, 8'h12, 8'h34, 8'h00, 8'h64, 8'hAB, 8'hCD};
        runMessage(msg, 0, 0, 1'b0);

        $display("[TB] reset in the middle of an add");
        msg = '{8'h41, 8'h01, 8'h00, 8'h55};
        applyStimulus(msg, 0);
        reset = 1'b1;
        #1;
        checkAllZero("mid-message reset");
        repeat (2) stepCycle();
        reset = 1'b0;
        stepCycle();
        lastExp  = '0;
        countExp = 0;
        errExp   = 0;
        checkOutput("no_start_across_reset", 32'(startSeen), 32'(startsExp));
        msg = '{8'h58, 8'h01, 8'h12, 8'h34};
        runMessage(msg, 0, 1, 1'b0);

        $display("[TB] randomized message stream");
        for (int k = 0; k < 40; k++) begin
            buildRandom(msg);
            runMessage(msg, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
        end

        $display("[TB] long builder wait");
        msg = '{8'h45, 8'h00, 8'hBE, 8'hEF, 8'h12, 8'h34};
        runMessage(msg, 0, 40, 1'b0);

        $display("[TB] error counter saturation");
        inByte  = 8'h7F;
        inValid = 1'b1;
        repeat (300) stepCycle();
        inValid = 1'b0;
        errPulsesExp += 300;
        errExp = 255;
        repeat (2) stepCycle();
        checkOutput("err_count_saturated", 32'(errCount), 32'(errExp));
        checkOutput("msg_err_idle", 32'(msgErr), 32'd0);

        checkOutput("start_pulse_total", 32'(startSeen), 32'(startsExp));
        checkOutput("err_pulse_total", 32'(errSeen), 32'(errPulsesExp));

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
